// File: rtl/itch_pkg.sv
// Shared ITCH definitions: Add Order byte layout, field record
// and per-type decoder states.
package itch_pkg;

    localparam logic [7:0] MSG_TYPE_ADD_ORDER = 8'h41;
    localparam int ADD_ORDER_LEN = 36;

    localparam int AO_REF_OFF  = 1,  AO_REF_LEN  = 8;
    localparam int AO_SIDE_OFF = 9;
    localparam int AO_SHR_OFF  = 10, AO_SHR_LEN  = 4;
    localparam int AO_PRC_OFF  = 14, AO_PRC_LEN  = 8;
    localparam int AO_TS_OFF   = 22, AO_TS_LEN   = 4;
    localparam int AO_MISC_OFF = 26, AO_MISC_LEN = 8;
    localparam int AO_FIRST    = 1,  AO_LAST     = 33;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_SKIP
    } dec_state_e;

    typedef struct packed {
        logic [63:0] order_ref;
        logic        side;
        logic [31:0] shares;
        logic [63:0] price;
        logic [31:0] timestamp;
        logic [63:0] misc_data;
    } add_order_t;

    typedef logic [AO_LAST:AO_FIRST][7:0] ao_bytes_t;

    // Multi-byte fields are big-endian: lowest offset is the MSB.
    function automatic add_order_t ao_unpack(input ao_bytes_t b);
        add_order_t r;
        r = '0;
        for (int i = 0; i < AO_REF_LEN; i++)
            r.order_ref[8*(AO_REF_LEN-1-i) +: 8] = b[AO_REF_OFF+i];
        r.side = b[AO_SIDE_OFF][0];
        for (int i = 0; i < AO_SHR_LEN; i++)
            r.shares[8*(AO_SHR_LEN-1-i) +: 8] = b[AO_SHR_OFF+i];
        for (int i = 0; i < AO_PRC_LEN; i++)
            r.price[8*(AO_PRC_LEN-1-i) +: 8] = b[AO_PRC_OFF+i];
        for (int i = 0; i < AO_TS_LEN; i++)
            r.timestamp[8*(AO_TS_LEN-1-i) +: 8] = b[AO_TS_OFF+i];
        for (int i = 0; i < AO_MISC_LEN; i++)
            r.misc_data[8*(AO_MISC_LEN-1-i) +: 8] = b[AO_MISC_OFF+i];
        return r;
    endfunction

endpackage

// File: rtl/itch_out_reg.sv
// One-entry valid/ready holding register; commits that find it full
// are dropped and counted with a saturating counter.
module itch_out_reg #(
    parameter int DATA_W     = 8,
    parameter int DROP_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  commit,
    input  logic [DATA_W-1:0]     commit_data,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    output logic [DROP_CNT_W-1:0] drop_count
);

    logic                  valid_q, valid_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic [DROP_CNT_W-1:0] drop_q, drop_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        drop_d  = drop_q;
        if (commit && valid_q && !out_ready) begin
            if (drop_q != '1)
                drop_d = drop_q + DROP_CNT_W'(1);
        end else if (commit) begin
            valid_d = 1'b1;
            data_d  = commit_data;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            drop_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            drop_q  <= drop_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign drop_count = drop_q;

endmodule

// File: rtl/add_order_decoder_mb.sv
// Multi-byte ITCH Add Order decoder: speculative type match, on-the-fly
// field capture, end-of-message length check, registered output.
module add_order_decoder_mb
    import itch_pkg::*;
#(
    parameter int         BEAT_BYTES = 4,
    parameter logic [7:0] MSG_TYPE   = MSG_TYPE_ADD_ORDER,
    parameter int         MSG_LENGTH = ADD_ORDER_LEN,
    parameter int         DROP_CNT_W = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [8*BEAT_BYTES-1:0]         data_in,
    input  logic                            valid_in,
    input  logic                            sop_in,
    input  logic                            eop_in,
    input  logic [$clog2(BEAT_BYTES+1)-1:0] keep_in,
    input  logic                            out_ready,
    output logic                            out_valid,
    output logic [63:0]                     order_ref,
    output logic                            side,
    output logic [31:0]                     shares,
    output logic [63:0]                     price,
    output logic [31:0]                     timestamp,
    output logic [63:0]                     misc_data,
    output logic                            packet_invalid,
    output logic [DROP_CNT_W-1:0]           drop_count
);

    localparam int CNT_W = $clog2(MSG_LENGTH + 2*BEAT_BYTES + 2);
    localparam logic [CNT_W-1:0] LEN_C = CNT_W'(MSG_LENGTH);
    localparam logic [CNT_W-1:0] SAT_C = CNT_W'(MSG_LENGTH + 1);

    dec_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ao_bytes_t        shadow_q, shadow_d;
    logic             pulse_q, pulse_d;

    logic             start, cont, match, wr_en, commit;
    logic [CNT_W-1:0] base, eff_keep, sum;
    add_order_t       held;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        pulse_d  = 1'b0;
        commit   = 1'b0;
        wr_en    = 1'b0;
        base     = '0;
        match    = (data_in[7:0] == MSG_TYPE);
        start    = valid_in && sop_in && (state_q != S_SKIP);
        cont     = valid_in && !sop_in && (state_q == S_ACTIVE);
        eff_keep = eop_in ? CNT_W'(keep_in) : CNT_W'(BEAT_BYTES);

        // A sop while ACTIVE abandons the old message but keeps the new beat.
        if (start && state_q == S_ACTIVE)
            pulse_d = 1'b1;

        if (start) begin
            if (match)
                wr_en = 1'b1;
            else
                state_d = eop_in ? S_IDLE : S_SKIP;
        end else if (cont) begin
            wr_en = 1'b1;
            base  = cnt_q;
        end else if (state_q == S_SKIP && valid_in && eop_in) begin
            state_d = S_IDLE;
        end

        sum = base + eff_keep;

        for (int j = AO_FIRST; j <= AO_LAST; j++)
            for (int l = 0; l < BEAT_BYTES; l++)
                if (wr_en && CNT_W'(l) < eff_keep &&
                    base + CNT_W'(l) == CNT_W'(j))
                    shadow_d[j] = data_in[8*l +: 8];

        if (wr_en) begin
            cnt_d = (sum > SAT_C) ? SAT_C : sum;
            if (eop_in) begin
                state_d = S_IDLE;
                cnt_d   = '0;
                if (sum == LEN_C)
                    commit = 1'b1;
                else
                    pulse_d = 1'b1;
            end else if (sum > LEN_C) begin
                state_d = S_SKIP;
                cnt_d   = '0;
                pulse_d = 1'b1;
            end else begin
                state_d = S_ACTIVE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            pulse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            pulse_q  <= pulse_d;
        end
    end

    itch_out_reg #(
        .DATA_W     ($bits(add_order_t)),
        .DROP_CNT_W (DROP_CNT_W)
    ) u_out_reg (
        .clk         (clk),
        .rst         (rst),
        .commit      (commit),
        .commit_data (ao_unpack(shadow_d)),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (held),
        .drop_count  (drop_count)
    );

    assign order_ref      = held.order_ref;
    assign side           = held.side;
    assign shares         = held.shares;
    assign price          = held.price;
    assign timestamp      = held.timestamp;
    assign misc_data      = held.misc_data;
    assign packet_invalid = pulse_q;

endmodule

// File: tb/tb_add_order_decoder_mb.sv
// Scoreboard bench for add_order_decoder_mb at 4-, 1- and 8-byte beats.
// Expected records are built from the message bytes as they are driven.
module tb_add_order_decoder_mb;

    typedef struct packed {
        logic [63:0] ord;
        logic        side;
        logic [31:0] sh;
        logic [63:0] pr;
        logic [31:0] ts;
        logic [63:0] misc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic out_ready = 1'b1;

    logic [63:0] din [3];
    logic        vin [3];
    logic        sop [3];
    logic        eop [3];
    logic [3:0]  keep [3];

    logic        ov [3];
    logic        sd [3];
    logic        pinv [3];
    logic [63:0] oref [3];
    logic [63:0] prc [3];
    logic [63:0] msc [3];
    logic [31:0] shr [3];
    logic [31:0] tsv [3];
    logic [15:0] drop [3];

    logic [7:0] mbuf [48];
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t mon_e;
    exp_t held_a;
    logic mon_ok;
    int npulse [3];
    int epulse [3];
    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    add_order_decoder_mb #(.BEAT_BYTES(4)) dut4 (
        .clk(clk), .rst(rst), .data_in(din[0][31:0]), .valid_in(vin[0]),
        .sop_in(sop[0]), .eop_in(eop[0]), .keep_in(keep[0][2:0]),
        .out_ready(out_ready), .out_valid(ov[0]), .order_ref(oref[0]),
        .side(sd[0]), .shares(shr[0]), .price(prc[0]), .timestamp(tsv[0]),
        .misc_data(msc[0]), .packet_invalid(pinv[0]), .drop_count(drop[0])
    );

    add_order_decoder_mb #(.BEAT_BYTES(1)) dut1 (
        .clk(clk), .rst(rst), .data_in(din[1][7:0]), .valid_in(vin[1]),
        .sop_in(sop[1]), .eop_in(eop[1]), .keep_in(keep[1][0:0]),
        .out_ready(out_ready), .out_valid(ov[1]), .order_ref(oref[1]),
        .side(sd[1]), .shares(shr[1]), .price(prc[1]), .timestamp(tsv[1]),
        .misc_data(msc[1]), .packet_invalid(pinv[1]), .drop_count(drop[1])
    );

    add_order_decoder_mb #(.BEAT_BYTES(8)) dut8 (
        .clk(clk), .rst(rst), .data_in(din[2]), .valid_in(vin[2]),
        .sop_in(sop[2]), .eop_in(eop[2]), .keep_in(keep[2]),
        .out_ready(out_ready), .out_valid(ov[2]), .order_ref(oref[2]),
        .side(sd[2]), .shares(shr[2]), .price(prc[2]), .timestamp(tsv[2]),
        .misc_data(msc[2]), .packet_invalid(pinv[2]), .drop_count(drop[2])
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic int bbv(input int inst);
        case (inst)
            0: return 4;
            1: return 1;
            default: return 8;
        endcase
    endfunction

    task automatic fill(input logic [7:0] t, input int seed);
        for (int i = 0; i < 48; i++)
            mbuf[i] = 8'(seed * 13 + i * 7 + 1);
        mbuf[0] = t;
    endtask

    function automatic exp_t model();
        exp_t e;
        e.ord  = {mbuf[1], mbuf[2], mbuf[3], mbuf[4],
                  mbuf[5], mbuf[6], mbuf[7], mbuf[8]};
        e.side = mbuf[9][0];
        e.sh   = {mbuf[10], mbuf[11], mbuf[12], mbuf[13]};
        e.pr   = {mbuf[14], mbuf[15], mbuf[16], mbuf[17],
                  mbuf[18], mbuf[19], mbuf[20], mbuf[21]};
        e.ts   = {mbuf[22], mbuf[23], mbuf[24], mbuf[25]};
        e.misc = {mbuf[26], mbuf[27], mbuf[28], mbuf[29],
                  mbuf[30], mbuf[31], mbuf[32], mbuf[33]};
        return e;
    endfunction

    task automatic push(input int inst);
        case (inst)
            0: q0.push_back(model());
            1: q1.push_back(model());
            default: q2.push_back(model());
        endcase
    endtask

    task automatic pop(input int inst, output logic ok, output exp_t e);
        ok = 1'b0;
        e  = '0;
        case (inst)
            0: if (q0.size() > 0) begin ok = 1'b1; e = q0.pop_front(); end
            1: if (q1.size() > 0) begin ok = 1'b1; e = q1.pop_front(); end
            default: if (q2.size() > 0) begin ok = 1'b1; e = q2.pop_front(); end
        endcase
    endtask

    task automatic send(input int inst, input int len, input logic with_eop);
        int bb;
        logic [63:0] d;
        bb = bbv(inst);
        for (int p = 0; p < len; p += bb) begin
            d = '0;
            for (int l = 0; l < bb; l++)
                if (p + l < len) d[8*l +: 8] = mbuf[p+l];
            din[inst]  = d;
            vin[inst]  = 1'b1;
            sop[inst]  = (p == 0);
            eop[inst]  = with_eop && (p + bb >= len);
            keep[inst] = 4'((p + bb >= len) ? len - p : bb);
            @(posedge clk); #1;
        end
        vin[inst] = 1'b0;
        sop[inst] = 1'b0;
        eop[inst] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_pulses(input string tag);
        for (int i = 0; i < 3; i++)
            chk(tag, 64'(npulse[i]), 64'(epulse[i]));
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                if (pinv[i]) npulse[i]++;
                if (ov[i] && out_ready) begin
                    pop(i, mon_ok, mon_e);
                    if (!mon_ok) begin
                        chk("unexpected_out", 64'(i), 64'hFF);
                    end else begin
                        chk("order_ref", oref[i], mon_e.ord);
                        chk("side", 64'(sd[i]), 64'(mon_e.side));
                        chk("shares", 64'(shr[i]), 64'(mon_e.sh));
                        chk("price", prc[i], mon_e.pr);
                        chk("timestamp", 64'(tsv[i]), 64'(mon_e.ts));
                        chk("misc_data", msc[i], mon_e.misc);
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            din[i] = '0; vin[i] = 1'b0; sop[i] = 1'b0;
            eop[i] = 1'b0; keep[i] = '0;
            npulse[i] = 0; epulse[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(ov[0]), 0);
        chk("rst_ref", oref[0], 0);
        chk("rst_drop", 64'(drop[0]), 0);
        chk("rst_pinv", 64'(pinv[0]), 0);
        rst = 1'b0;

        // legal message, known field values, latency 1
        fill(8'h41, 1);
        for (int i = 1; i <= 8; i++) mbuf[i] = 8'(i);
        for (int i = 14; i <= 21; i++) mbuf[i] = 8'h00;
        mbuf[19] = 8'h0F; mbuf[20] = 8'h42; mbuf[21] = 8'h40;
        push(0);
        send(0, 36, 1'b1);
        chk("t1_latency", 64'(ov[0]), 1);
        chk("t1_ref", oref[0], 64'h0102030405060708);
        chk("t1_price", prc[0], 64'h00000000000F4240);
        chk("t1_pinv", 64'(pinv[0]), 0);
        idle(1);
        chk("t1_fall", 64'(ov[0]), 0);

        // foreign type skipped, then a legal one
        fill(8'h45, 2);
        send(0, 36, 1'b1);
        fill(8'h41, 3);
        push(0);
        send(0, 36, 1'b1);
        idle(3);
        chk_pulses("t2_pulses");

        // short message, then overlong message
        fill(8'h41, 4);
        send(0, 32, 1'b1);
        epulse[0]++;
        idle(3);
        chk_pulses("t3_short");
        chk("t3_valid", 64'(ov[0]), 0);
        fill(8'h41, 5);
        send(0, 40, 1'b1);
        epulse[0]++;
        idle(3);
        chk_pulses("t3_long");
        chk("t3_valid2", 64'(ov[0]), 0);

        // backpressure: second message dropped, first held
        out_ready = 1'b0;
        fill(8'h41, 6);
        held_a = model();
        push(0);
        send(0, 36, 1'b1);
        fill(8'h41, 7);
        send(0, 36, 1'b1);
        chk("t4_drop", 64'(drop[0]), 1);
        chk("t4_valid", 64'(ov[0]), 1);
        chk("t4_hold", oref[0], held_a.ord);
        idle(2);
        chk("t4_hold2", prc[0], held_a.pr);
        out_ready = 1'b1;
        idle(1);
        chk("t4_fall", 64'(ov[0]), 0);

        // restart on sop mid-message at each beat width
        for (int i = 0; i < 3; i++) begin
            fill(8'h41, 10 + i);
            send(i, (i == 2) ? 32 : 20, 1'b0);
            epulse[i]++;
            fill(8'h41, 20 + i);
            push(i);
            send(i, 36, 1'b1);
            idle(3);
        end
        chk_pulses("t5_pulses");

        // reset mid-message
        fill(8'h41, 30);
        send(0, 12, 1'b0);
        rst = 1'b1;
        idle(2);
        chk("t6_valid", 64'(ov[0]), 0);
        chk("t6_ref", oref[0], 0);
        chk("t6_price", prc[0], 0);
        chk("t6_drop", 64'(drop[0]), 0);
        chk("t6_pinv", 64'(pinv[0]), 0);
        rst = 1'b0;
        fill(8'h41, 31);
        push(0);
        send(0, 36, 1'b1);
        idle(4);
        chk_pulses("t6_pulses");

        chk("drain0", 64'(q0.size()), 0);
        chk("drain1", 64'(q1.size()), 0);
        chk("drain2", 64'(q2.size()), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
